// File: rtl/square_detector.sv
// Per-frame bright-object locator: tracks the bounding box of pixels at or above
// THRESHOLD and publishes it as a square one cycle after the last active pixel.
module square_detector #(
  parameter int THRESHOLD  = 200,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 16,
  parameter int MIN_SIZE   = 4
) (
  input  logic        VGA_CLK,
  input  logic        RST,
  input  logic [7:0]  pixel_in,
  input  logic [12:0] VGA_H_CNT,
  input  logic [12:0] VGA_V_CNT,
  output logic [10:0] square_x,
  output logic [10:0] square_y,
  output logic [10:0] square_size,
  output logic        square_detected,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

  state_t      state, state_n;
  logic [10:0] min_x, min_y, max_x, max_y;
  logic [10:0] min_x_n, min_y_n, max_x_n, max_y_n;
  logic [18:0] cnt, cnt_n;

  logic        active, bright, fstart, fend, publish, det;
  logic [10:0] h11, v11, size_c;
  logic [11:0] w, h, size12;

  function automatic logic [18:0] sat_inc(input logic [18:0] c);
    return (&c) ? c : c + 19'd1;
  endfunction

  function automatic logic [10:0] clamp_size(input logic [11:0] s);
    return (s > 12'h7FF) ? 11'h7FF : s[10:0];
  endfunction

  assign active = (VGA_H_CNT < 13'(H_ACTIVE)) && (VGA_V_CNT < 13'(V_ACTIVE));
  assign bright = active && (pixel_in >= 8'(THRESHOLD));
  assign fstart = (VGA_H_CNT == 13'd0) && (VGA_V_CNT == 13'd0);
  assign fend   = (VGA_H_CNT == 13'(H_ACTIVE - 1)) && (VGA_V_CNT == 13'(V_ACTIVE - 1));
  // Coordinates are only consumed when active, so the low 11 bits are exact.
  assign h11    = VGA_H_CNT[10:0];
  assign v11    = VGA_V_CNT[10:0];

  always_comb begin
    state_n = state;
    min_x_n = min_x;
    min_y_n = min_y;
    max_x_n = max_x;
    max_y_n = max_y;
    cnt_n   = cnt;
    case (state)
      IDLE, ACCUM: begin
        if (fstart) begin
          min_x_n = bright ? 11'd0 : 11'h7FF;
          min_y_n = bright ? 11'd0 : 11'h7FF;
          max_x_n = 11'd0;
          max_y_n = 11'd0;
          cnt_n   = bright ? 19'd1 : 19'd0;
          state_n = ACCUM;
        end else if (state == ACCUM) begin
          if (bright) begin
            if (h11 < min_x) min_x_n = h11;
            if (v11 < min_y) min_y_n = v11;
            if (h11 > max_x) max_x_n = h11;
            if (v11 > max_y) max_y_n = v11;
            cnt_n = sat_inc(cnt);
          end
          if (fend) state_n = LATCH;
        end
      end
      LATCH:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // The box is evaluated on the folded values so the result lands on the edge
  // right after the frame-end pixel, together with the LATCH state.
  assign w       = {1'b0, max_x_n} - {1'b0, min_x_n} + 12'd1;
  assign h       = {1'b0, max_y_n} - {1'b0, min_y_n} + 12'd1;
  assign size12  = (w > h) ? w : h;
  assign size_c  = clamp_size(size12);
  assign det     = (cnt_n >= 19'(MIN_PIXELS)) && (cnt_n != 19'd0) && (size_c >= 11'(MIN_SIZE));
  assign publish = (state == ACCUM) && (state_n == LATCH);

  always_ff @(posedge VGA_CLK or posedge RST) begin
    if (RST) begin
      state           <= IDLE;
      min_x           <= 11'h7FF;
      min_y           <= 11'h7FF;
      max_x           <= 11'd0;
      max_y           <= 11'd0;
      cnt             <= 19'd0;
      square_x        <= 11'd0;
      square_y        <= 11'd0;
      square_size     <= 11'd0;
      square_detected <= 1'b0;
    end else begin
      state <= state_n;
      min_x <= min_x_n;
      min_y <= min_y_n;
      max_x <= max_x_n;
      max_y <= max_y_n;
      cnt   <= cnt_n;
      if (publish) begin
        square_detected <= det;
        if (det) begin
          square_x    <= min_x_n;
          square_y    <= min_y_n;
          square_size <= size_c;
        end
      end
    end
  end

  assign frame_done = (state == LATCH);

endmodule

// File: tb/tb_square_detector.sv
// Directed-frame bench for square_detector: sparse counter sequences build each
// frame, expected squares go through a scoreboard checked on every frame_done.
module tb_square_detector;

  logic        VGA_CLK = 1'b0;
  logic        RST;
  logic [7:0]  pixel_in;
  logic [12:0] VGA_H_CNT, VGA_V_CNT;
  logic [10:0] square_x, square_y, square_size;
  logic        square_detected, frame_done;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] s;
    logic        d;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  square_detector dut (
    .VGA_CLK        (VGA_CLK),
    .RST            (RST),
    .pixel_in       (pixel_in),
    .VGA_H_CNT      (VGA_H_CNT),
    .VGA_V_CNT      (VGA_V_CNT),
    .square_x       (square_x),
    .square_y       (square_y),
    .square_size    (square_size),
    .square_detected(square_detected),
    .frame_done     (frame_done)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every frame_done pulse consumes one scoreboard entry.
  always @(negedge VGA_CLK) begin
    if (!RST && frame_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame_done actual=1 required=0 at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("square_x", 32'(square_x), 32'(e.x));
        chk("square_y", 32'(square_y), 32'(e.y));
        chk("square_size", 32'(square_size), 32'(e.s));
        chk("square_detected", 32'(square_detected), 32'(e.d));
      end
    end
  end

  task automatic pix(input int hc, input int vc, input int val);
    VGA_H_CNT = 13'(hc);
    VGA_V_CNT = 13'(vc);
    pixel_in  = 8'(val);
    @(posedge VGA_CLK);
    #1;
  endtask

  function automatic bit in_blk(input int x, y, bx, by, bw, bh);
    return (x >= bx) && (x < bx + bw) && (y >= by) && (y < by + bh);
  endfunction

  task automatic run_frame(input int bx, by, bw, bh, input int val,
                           input int ex, ey, es, input bit ed);
    sb_q.push_back('{11'(ex), 11'(ey), 11'(es), ed});
    pix(0, 0, in_blk(0, 0, bx, by, bw, bh) ? val : 0);
    pix(5, 0, 0);
    for (int y = by; y < by + bh; y++)
      for (int x = bx; x < bx + bw; x++)
        if (!(x == 0 && y == 0) && !(x == 639 && y == 479)) pix(x, y, val);
    pix(320, 470, 0);
    pix(639, 479, in_blk(639, 479, bx, by, bw, bh) ? val : 0);
    chk("frame_done_latency", 32'(frame_done), 32'd1);
    pix(700, 520, 0);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
    pix(700, 521, 0);
  endtask

  initial begin
    RST = 1'b1;
    pixel_in = 8'd0;
    VGA_H_CNT = 13'd700;
    VGA_V_CNT = 13'd500;
    repeat (3) @(posedge VGA_CLK);
    #1;
    chk("rst_square_x", 32'(square_x), 32'd0);
    chk("rst_square_y", 32'(square_y), 32'd0);
    chk("rst_square_size", 32'(square_size), 32'd0);
    chk("rst_detected", 32'(square_detected), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    RST = 1'b0;
    pix(700, 500, 0);

    run_frame(100, 50, 20, 20, 255, 100, 50, 20, 1);   // 20x20 block
    run_frame(0, 0, 0, 0, 0, 100, 50, 20, 0);          // empty frame holds box
    run_frame(200, 300, 30, 10, 255, 200, 300, 30, 1); // 30x10 -> size 30
    run_frame(10, 10, 4, 4, 200, 10, 10, 4, 1);        // threshold inclusive
    run_frame(20, 20, 4, 4, 199, 10, 10, 4, 0);        // just below threshold
    run_frame(30, 30, 2, 4, 255, 10, 10, 4, 0);        // 8 pixels only

    // Bright pixels only in blanking.
    sb_q.push_back('{11'd10, 11'd10, 11'd4, 1'b0});
    pix(0, 0, 0);
    for (int x = 640; x <= 650; x++) pix(x, 10, 255);
    pix(5, 480, 255);
    pix(639, 479, 0);
    chk("blank_frame_done", 32'(frame_done), 32'd1);
    pix(700, 520, 0);

    run_frame(0, 0, 4, 4, 255, 0, 0, 4, 1);            // bright frame-start pixel
    run_frame(636, 476, 4, 4, 255, 636, 476, 4, 1);    // bright frame-end pixel

    // Reset mid-frame after a valid block has been seen.
    pix(0, 0, 0);
    for (int y = 50; y < 70; y++)
      for (int x = 100; x < 120; x++) pix(x, y, 255);
    pix(0, 200, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("midrst_square_x", 32'(square_x), 32'd0);
    chk("midrst_square_y", 32'(square_y), 32'd0);
    chk("midrst_square_size", 32'(square_size), 32'd0);
    chk("midrst_detected", 32'(square_detected), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    @(posedge VGA_CLK);
    #1;
    RST = 1'b0;
    pix(1, 201, 0);
    pix(300, 300, 255);
    pix(639, 479, 0);
    chk("no_done_after_reset", 32'(frame_done), 32'd0);
    pix(700, 520, 0);

    run_frame(100, 50, 20, 20, 255, 100, 50, 20, 1);

    repeat (4) pix(700, 520, 0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/square_detector.md
Name: square_detector

Overview:
- Per-frame bright-object locator. Sits directly upstream of the square masking stage and drives its square_x, square_y, square_size and square_detected inputs.
- Scans the incoming pixel stream against the VGA counters and tracks the bounding box of all pixels at or above a brightness threshold.
- At the end of each active frame it publishes the box as a square; the values stay stable for the whole following frame.

Parameters:
- THRESHOLD, 200: minimum pixel_in value counted as bright (inclusive).
- H_ACTIVE, 640: active pixels per line; valid H range is 0..H_ACTIVE-1.
- V_ACTIVE, 480: active lines per frame; valid V range is 0..V_ACTIVE-1.
- MIN_PIXELS, 16: minimum bright-pixel count for a detection.
- MIN_SIZE, 4: minimum square_size for a detection.

Ports:
- VGA_CLK  in  1  pixel clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- pixel_in  in  8  grey pixel, aligned with VGA_H_CNT/VGA_V_CNT in the same cycle.
- VGA_H_CNT  in  13  horizontal counter.
- VGA_V_CNT  in  13  vertical counter.
- square_x  out  11  bounding-box left edge.
- square_y  out  11  bounding-box top edge.
- square_size  out  11  square side length.
- square_detected  out  1  valid-detection flag.
- frame_done  out  1  one-cycle pulse when the outputs update.

Behaviour:
- Reset (asynchronous, active-high): all outputs go to 0, the FSM goes to IDLE, and the accumulators are cleared.
- A cycle is "active" when VGA_H_CNT < H_ACTIVE and VGA_V_CNT < V_ACTIVE.
- A pixel is "bright" when it is active and pixel_in >= THRESHOLD.
- Frame start: VGA_H_CNT==0 and VGA_V_CNT==0.
- Frame end: VGA_H_CNT==H_ACTIVE-1 and VGA_V_CNT==V_ACTIVE-1.
- Accumulators:
  - min_x, min_y: 11 bits, sentinel 11'h7FF.
  - max_x, max_y: 11 bits, sentinel 0.
  - cnt: 19 bits, saturating at all-ones.
- FSM states:
  - IDLE: wait for frame start. On frame start, load the accumulators from the current pixel (bright gives min=max=(0,0) and cnt=1; otherwise sentinels and cnt=0), then go to ACCUM.
  - ACCUM: on each bright pixel, min/max take the min/max with the current H/V and cnt increments. Non-active cycles are ignored. On frame end, fold in that final pixel and go to LATCH. A frame start seen in ACCUM (timing glitch) reloads the accumulators as in IDLE and stays in ACCUM.
  - LATCH: a single cycle.
    - frame_done=1.
    - Compute w=max_x-min_x+1, h=max_y-min_y+1 and size=max(w,h).
    - If cnt>=MIN_PIXELS and cnt!=0 and size>=MIN_SIZE: square_x<=min_x, square_y<=min_y, square_size<=size, square_detected<=1.
    - Otherwise square_detected<=0 and square_x/y/size hold their previous values.
    - Then go to IDLE.
- Latency: outputs and frame_done change on the first VGA_CLK edge after the cycle in which frame end is sampled (one cycle).
- frame_done is 0 in every state except LATCH.
- Width rules:
  - size is computed in 12 bits and clamped to 11'h7FF.
  - square_x + square_size is never forced in range; downstream handles any overflow.
- Reset mid-frame: the partial frame is discarded and nothing is published until a full frame start-to-end sequence completes.
- Bright pixels in blanking (H >= H_ACTIVE or V >= V_ACTIVE) never affect the accumulators.
- A single bright pixel is detected only if MIN_PIXELS<=1 and MIN_SIZE<=1.

Test Plan:
1. Default parameters; filled bright 20x20 block at x=100..119, y=50..69, value 255; all other pixels 0.
   -> One cycle after (639,479): frame_done=1, square_x=100, square_y=50, square_size=20, square_detected=1.
2. Bright 30x10 rectangle at x=200..229, y=300..309.
   -> square_x=200, square_y=300, square_size=30, detected=1.
3. After scenario 1, send an all-zero frame.
   -> detected=0; square_x=100, y=50 and size=20 are held; frame_done pulses once.
4. Threshold and count boundaries:
   - 4x4 block of value 200 -> detected=1, size=4.
   - Same block at value 199 -> detected=0.
   - 2x4 block of value 255 (8 pixels < MIN_PIXELS) -> detected=0.
5. Blanking rejection: bright pixels only at H=640..650 on visible lines plus one at V=480.
   -> detected=0.
6. Assert RST while mid-frame (V=200) with a valid block above that line.
   -> All outputs 0 immediately, and frame_done does not pulse in that frame. The next full frame containing the scenario 1 block reports x=100, y=50, size=20, detected=1.
